icache_mem_arbiter: RTL and testbench

//  Two-port memory arbiter sharing one valid/ready memory port between the icache refill

---
 rtl/kianv_arb_pkg.sv | 15 +
 rtl/icache_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_icache_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/kianv_arb_pkg.sv
// -----------------------------------------------------------------------------
// kianv_arb_pkg
//   Shared constants for the icache / data-port memory arbiter.
//   ARB_IDLE / ARB_GNT_I / ARB_GNT_D : arbiter FSM state encodings
//   ARB_WSTRB_W                      : width of the byte-strobe buses
// -----------------------------------------------------------------------------
package kianv_arb_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GNT_I = 2'd1;
    localparam logic [1:0] ARB_GNT_D = 2'd2;

    localparam int ARB_WSTRB_W = 4;

endpackage

// File: rtl/icache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// icache_mem_arbiter
//   Shares one valid/ready memory port between the icache refill port and the
//   CPU data port. Registered grant, one transaction at a time, fixed priority
//   with a starvation counter that forces a swap after STARVE_LIMIT
//   back-to-back preferred grants while the other port waits.
//
//   Ports
//     clk, resetn                 clock, synchronous active-low reset
//     ic_valid_i, ic_addr_i       icache refill request (read only)
//     ic_rdata_o, ic_ready_o      icache read data / completion pulse
//     dm_valid_i, dm_addr_i,
//     dm_wdata_i, dm_wstrb_i      CPU data request (wstrb 0 = read)
//     dm_rdata_o, dm_ready_o      CPU read data / completion pulse
//     mem_valid_o, mem_addr_o,
//     mem_wdata_o, mem_wstrb_o    muxed request towards memory
//     mem_rdata_i, mem_ready_i    memory response
// -----------------------------------------------------------------------------
module icache_mem_arbiter
    import kianv_arb_pkg::*;
#(
    parameter int PRIO_DATA    = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ic_valid_i,
    input  logic [31:0]            ic_addr_i,
    output logic [31:0]            ic_rdata_o,
    output logic                   ic_ready_o,
    input  logic                   dm_valid_i,
    input  logic [31:0]            dm_addr_i,
    input  logic [31:0]            dm_wdata_i,
    input  logic [ARB_WSTRB_W-1:0] dm_wstrb_i,
    output logic [31:0]            dm_rdata_o,
    output logic                   dm_ready_o,
    output logic                   mem_valid_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    output logic [ARB_WSTRB_W-1:0] mem_wstrb_o,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   mem_ready_i
);

    localparam int              CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam bit              DATA_PREF = (PRIO_DATA != 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    // Remembers whether the non-granted port was already waiting when the
    // current grant was made; decides increment vs. clear at completion.
    logic             other_wait_q, other_wait_d;

    logic             swap;
    logic             grant_data;

    // Read data is broadcast; each consumer qualifies it with its own ready.
    assign ic_rdata_o = mem_rdata_i;
    assign dm_rdata_o = mem_rdata_i;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            starve_q     <= '0;
            other_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            other_wait_q <= other_wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        other_wait_d = other_wait_q;
        swap         = (starve_q == CNT_LIMIT);
        grant_data   = DATA_PREF ? !swap : swap;
        case (state_q)
            ARB_IDLE: begin
                if (ic_valid_i && dm_valid_i) begin
                    state_d      = grant_data ? ARB_GNT_D : ARB_GNT_I;
                    other_wait_d = 1'b1;
                end else if (ic_valid_i) begin
                    state_d      = ARB_GNT_I;
                    other_wait_d = 1'b0;
                end else if (dm_valid_i) begin
                    state_d      = ARB_GNT_D;
                    other_wait_d = 1'b0;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                // A dropped valid abandons the transaction without touching
                // the counter; otherwise wait for the memory to complete.
                if (!((state_q == ARB_GNT_D) ? dm_valid_i : ic_valid_i)) begin
                    state_d = ARB_IDLE;
                end else if (mem_ready_i) begin
                    state_d = ARB_IDLE;
                    if (((state_q == ARB_GNT_D) == DATA_PREF) && other_wait_q) begin
                        if (starve_q != CNT_LIMIT) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output mux: the grant alone steers the memory port.
    always_comb begin
        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        ic_ready_o  = 1'b0;
        dm_ready_o  = 1'b0;
        case (state_q)
            ARB_GNT_I: begin
                mem_valid_o = ic_valid_i;
                mem_addr_o  = ic_addr_i;
                ic_ready_o  = mem_ready_i & ic_valid_i;
            end
            ARB_GNT_D: begin
                mem_valid_o = dm_valid_i;
                mem_addr_o  = dm_addr_i;
                mem_wdata_o = dm_wdata_i;
                mem_wstrb_o = dm_wstrb_i;
                dm_ready_o  = mem_ready_i & dm_valid_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_mem_arbiter.sv
module tb_icache_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ic_valid_i;
    logic [31:0] ic_addr_i;
    logic [31:0] ic_rdata_o;
    logic        ic_ready_o;
    logic        dm_valid_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [3:0]  dm_wstrb_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_valid_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_mem_arbiter #(.PRIO_DATA(1), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ic_valid_i  (ic_valid_i),
        .ic_addr_i   (ic_addr_i),
        .ic_rdata_o  (ic_rdata_o),
        .ic_ready_o  (ic_ready_o),
        .dm_valid_i  (dm_valid_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_wstrb_i  (dm_wstrb_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .mem_valid_o (mem_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge; inputs are changed there and outputs
    // are sampled 1 time unit later, well away from the rising edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".mem_valid"}, 32'(mem_valid_o), 32'd0);
        chk({tag, ".mem_addr"},  mem_addr_o,       32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata_o,      32'd0);
        chk({tag, ".mem_wstrb"}, 32'(mem_wstrb_o), 32'd0);
        chk({tag, ".ic_ready"},  32'(ic_ready_o),  32'd0);
        chk({tag, ".dm_ready"},  32'(dm_ready_o),  32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        ic_valid_i  = 1'b0;
        ic_addr_i   = 32'h0;
        dm_valid_i  = 1'b0;
        dm_addr_i   = 32'h0;
        dm_wdata_i  = 32'h0;
        dm_wstrb_i  = 4'h0;
        mem_rdata_i = 32'h0;
        mem_ready_i = 1'b0;

        // ---- reset state
        cyc(); cyc(); #1;
        chk_idle_outputs("reset");
        chk("reset.state", 32'(dut.state_q), 32'd0);
        chk("reset.cnt", 32'(dut.starve_q), 32'd0);
        $display("txn reset: outputs idle");

        // ---- mem_ready while IDLE is ignored
        cyc(); resetn = 1'b1; mem_ready_i = 1'b1; #1;
        chk("idle_rdy.ic_ready", 32'(ic_ready_o), 32'd0);
        chk("idle_rdy.dm_ready", 32'(dm_ready_o), 32'd0);
        cyc(); mem_ready_i = 1'b0; #1;
        chk("idle_rdy.state", 32'(dut.state_q), 32'd0);
        $display("txn idle mem_ready ignored");

        // ---- single icache read, ready 3 cycles after grant
        cyc(); ic_valid_i = 1'b1; ic_addr_i = 32'h100; #1;
        chk("ic_rd.c0_valid", 32'(mem_valid_o), 32'd0);
        cyc(); #1;
        chk("ic_rd.c1_valid", 32'(mem_valid_o), 32'd1);
        chk("ic_rd.c1_addr", mem_addr_o, 32'h100);
        chk("ic_rd.c1_wstrb", 32'(mem_wstrb_o), 32'd0);
        chk("ic_rd.c1_ic_ready", 32'(ic_ready_o), 32'd0);
        cyc(); #1;
        chk("ic_rd.c2_valid", 32'(mem_valid_o), 32'd1);
        cyc(); #1;
        chk("ic_rd.c3_valid", 32'(mem_valid_o), 32'd1);
        cyc(); mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
        chk("ic_rd.c4_valid", 32'(mem_valid_o), 32'd1);
        chk("ic_rd.c4_ic_ready", 32'(ic_ready_o), 32'd1);
        chk("ic_rd.c4_rdata", ic_rdata_o, 32'hDEADBEEF);
        chk("ic_rd.c4_dm_ready", 32'(dm_ready_o), 32'd0);
        cyc(); ic_valid_i = 1'b0; mem_ready_i = 1'b0; #1;
        chk("ic_rd.c5_valid", 32'(mem_valid_o), 32'd0);
        chk("ic_rd.c5_ic_ready", 32'(ic_ready_o), 32'd0);
        $display("txn icache read addr=0x100 rdata=0xdeadbeef");

        // ---- simultaneous requests: data first, icache after one IDLE cycle
        cyc(); ic_valid_i = 1'b1; ic_addr_i = 32'h100;
        dm_valid_i = 1'b1; dm_addr_i = 32'h200; #1;
        chk("both.c0_valid", 32'(mem_valid_o), 32'd0);
        cyc(); mem_ready_i = 1'b1; #1;
        chk("both.c1_addr", mem_addr_o, 32'h200);
        chk("both.c1_dm_ready", 32'(dm_ready_o), 32'd1);
        chk("both.c1_ic_ready", 32'(ic_ready_o), 32'd0);
        cyc(); dm_valid_i = 1'b0; mem_ready_i = 1'b0; #1;
        chk("both.c2_valid", 32'(mem_valid_o), 32'd0);
        chk("both.c2_cnt", 32'(dut.starve_q), 32'd1);
        cyc(); mem_ready_i = 1'b1; #1;
        chk("both.c3_addr", mem_addr_o, 32'h100);
        chk("both.c3_ic_ready", 32'(ic_ready_o), 32'd1);
        chk("both.c3_dm_ready", 32'(dm_ready_o), 32'd0);
        cyc(); ic_valid_i = 1'b0; mem_ready_i = 1'b0; #1;
        chk("both.c4_cnt", 32'(dut.starve_q), 32'd0);
        $display("txn simultaneous: data then icache");

        // ---- starvation: four data grants then a forced icache grant
        cyc(); ic_valid_i = 1'b1; ic_addr_i = 32'h100;
        dm_valid_i = 1'b1; dm_addr_i = 32'h300; #1;
        for (int k = 0; k < 4; k++) begin
            chk("starve.idle_valid", 32'(mem_valid_o), 32'd0);
            cyc(); mem_ready_i = 1'b1; #1;
            chk("starve.d_addr", mem_addr_o, 32'h300);
            chk("starve.d_ready", 32'(dm_ready_o), 32'd1);
            cyc(); mem_ready_i = 1'b0; #1;
            chk("starve.cnt", 32'(dut.starve_q), 32'(k + 1));
            $display("txn starve data grant %0d", k + 1);
        end
        chk("starve.idle5_valid", 32'(mem_valid_o), 32'd0);
        cyc(); mem_ready_i = 1'b1; #1;
        chk("starve.i_addr", mem_addr_o, 32'h100);
        chk("starve.i_ready", 32'(ic_ready_o), 32'd1);
        chk("starve.i_dm_ready", 32'(dm_ready_o), 32'd0);
        cyc(); mem_ready_i = 1'b0; ic_valid_i = 1'b0; dm_valid_i = 1'b0; #1;
        chk("starve.cnt_clear", 32'(dut.starve_q), 32'd0);
        $display("txn starve forced icache grant");

        // ---- store passthrough
        cyc(); dm_valid_i = 1'b1; dm_addr_i = 32'h8000_0004;
        dm_wdata_i = 32'h1234ABCD; dm_wstrb_i = 4'b0011; #1;
        chk("store.c0_valid", 32'(mem_valid_o), 32'd0);
        cyc(); #1;
        chk("store.valid", 32'(mem_valid_o), 32'd1);
        chk("store.addr", mem_addr_o, 32'h8000_0004);
        chk("store.wdata", mem_wdata_o, 32'h1234ABCD);
        chk("store.wstrb", 32'(mem_wstrb_o), 32'h3);
        chk("store.no_ready", 32'(dm_ready_o), 32'd0);
        cyc(); mem_ready_i = 1'b1; #1;
        chk("store.ready", 32'(dm_ready_o), 32'd1);
        cyc(); mem_ready_i = 1'b0; dm_valid_i = 1'b0; dm_wstrb_i = 4'h0; #1;
        chk("store.ready_gone", 32'(dm_ready_o), 32'd0);
        chk("store.idle_valid", 32'(mem_valid_o), 32'd0);
        $display("txn store addr=0x80000004 wdata=0x1234abcd wstrb=0011");

        // ---- abort: icache drops valid, pending data granted next
        cyc(); ic_valid_i = 1'b1; ic_addr_i = 32'h140; #1;
        cyc(); dm_valid_i = 1'b1; dm_addr_i = 32'h240; #1;
        chk("abort.grant_i_addr", mem_addr_o, 32'h140);
        chk("abort.grant_i_valid", 32'(mem_valid_o), 32'd1);
        cyc(); ic_valid_i = 1'b0; #1;
        chk("abort.drop_ic_ready", 32'(ic_ready_o), 32'd0);
        chk("abort.drop_valid", 32'(mem_valid_o), 32'd0);
        cyc(); #1;
        chk("abort.idle_state", 32'(dut.state_q), 32'd0);
        chk("abort.idle_valid", 32'(mem_valid_o), 32'd0);
        chk("abort.cnt", 32'(dut.starve_q), 32'd0);
        cyc(); mem_ready_i = 1'b1; #1;
        chk("abort.d_addr", mem_addr_o, 32'h240);
        chk("abort.d_ready", 32'(dm_ready_o), 32'd1);
        chk("abort.ic_ready", 32'(ic_ready_o), 32'd0);
        cyc(); mem_ready_i = 1'b0; dm_valid_i = 1'b0; #1;
        $display("txn abort icache, data granted next");

        // ---- reset in the middle of a data grant
        cyc(); dm_valid_i = 1'b1; dm_addr_i = 32'h400; dm_wdata_i = 32'h55AA55AA;
        dm_wstrb_i = 4'hF; #1;
        cyc(); resetn = 1'b0; #1;
        chk("rst_mid.gnt_valid", 32'(mem_valid_o), 32'd1);
        cyc(); resetn = 1'b1; #1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid.state", 32'(dut.state_q), 32'd0);
        cyc(); mem_ready_i = 1'b1; #1;
        chk("rst_mid.next_addr", mem_addr_o, 32'h400);
        chk("rst_mid.next_wstrb", 32'(mem_wstrb_o), 32'hF);
        chk("rst_mid.next_ready", 32'(dm_ready_o), 32'd1);
        cyc(); mem_ready_i = 1'b0; dm_valid_i = 1'b0; dm_wstrb_i = 4'h0; #1;
        chk("rst_mid.end_valid", 32'(mem_valid_o), 32'd0);
        $display("txn reset mid data grant, next request normal");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
